// File: rtl/ladybird_fifo_lvl.sv
// Valid/ready FIFO with occupancy count, registered almost-full/almost-empty flags and synchronous flush.
// Define LADYBIRD_FIFO_LVL_OUTREG_EN to add a one-word registered output stage (capacity DEPTH+1).
module ladybird_fifo_lvl #(
  parameter int DEPTH_W   = 5,
  parameter int DATA_W    = 8,
  parameter int AFULL_TH  = (1 << DEPTH_W) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [DATA_W-1:0]  a_data,
  input  logic               a_valid,
  output logic               a_ready,
  output logic [DATA_W-1:0]  b_data,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [DEPTH_W:0]   count,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W+1)'(DEPTH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_th
    $error("ladybird_fifo_lvl: AFULL_TH must be 1..DEPTH and AEMPTY_TH 0..DEPTH-1");
  end

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W:0]   mem_cnt;
  logic [DEPTH_W:0]   count_nxt;
  logic               mem_rd;
  logic               wr_fire;
  logic               rd_fire;

  // Readiness follows memory fullness only, never the consumer side.
  assign a_ready = (mem_cnt != DEPTH_CNT) & ~flush;
  assign wr_fire = a_valid & a_ready;
  assign rd_fire = b_valid & b_ready;

`ifdef LADYBIRD_FIFO_LVL_OUTREG_EN
  logic              stage_vld;
  logic [DATA_W-1:0] stage_dat;

  assign mem_rd  = (~stage_vld | rd_fire) & (mem_cnt != '0) & ~flush;
  assign b_valid = stage_vld & ~flush;
  assign b_data  = stage_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_vld <= 1'b0;
      stage_dat <= '0;
    end else if (flush) begin
      stage_vld <= 1'b0;
      stage_dat <= '0;
    end else if (mem_rd) begin
      stage_vld <= 1'b1;
      stage_dat <= mem[rd_ptr];
    end else if (rd_fire) begin
      stage_vld <= 1'b0;
    end
  end
`else
  assign mem_rd  = rd_fire;
  assign b_valid = (mem_cnt != '0) & ~flush;
  assign b_data  = mem[rd_ptr];
`endif

  // External count moves only on external handshakes, so it covers the stage word too.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_fire & ~rd_fire) begin
      count_nxt = count + 1'b1;
    end else if (rd_fire & ~wr_fire) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      mem_cnt      <= '0;
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count        <= count_nxt;
      almost_full  <= int'(count_nxt) >= AFULL_TH;
      almost_empty <= int'(count_nxt) <= AEMPTY_TH;
      if (flush) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        mem_cnt <= '0;
      end else begin
        if (wr_fire) begin
          mem[wr_ptr] <= a_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (mem_rd) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_fire & ~mem_rd) begin
          mem_cnt <= mem_cnt + 1'b1;
        end else if (mem_rd & ~wr_fire) begin
          mem_cnt <= mem_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ladybird_fifo_lvl.sv
// Bench for ladybird_fifo_lvl (DEPTH_W=2, AFULL_TH=3, AEMPTY_TH=1, combinational-read build) against a queue model.
module tb_ladybird_fifo_lvl;

  localparam int DEPTH_W = 2;
  localparam int DEPTH   = 4;
  localparam int AF_TH   = 3;
  localparam int AE_TH   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready = 1'b0;
  logic [DEPTH_W:0] count;
  logic       almost_full;
  logic       almost_empty;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] q[$];

  ladybird_fifo_lvl #(.DEPTH_W(DEPTH_W), .DATA_W(8), .AFULL_TH(AF_TH), .AEMPTY_TH(AE_TH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then let the model take the edge.
  task automatic step(input logic av, input logic [7:0] ad, input logic br, input logic fl);
    bit exp_rdy, exp_vld;
    a_valid = av; a_data = ad; b_ready = br; flush = fl;
    #1;
    exp_rdy = !fl && q.size() < DEPTH;
    exp_vld = !fl && q.size() > 0;
    chk("count", count, q.size());
    chk("a_ready", a_ready, exp_rdy);
    chk("b_valid", b_valid, exp_vld);
    if (exp_vld) chk("b_data", b_data, q[0]);
    chk("almost_full", almost_full, q.size() >= AF_TH);
    chk("almost_empty", almost_empty, q.size() <= AE_TH);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (br && exp_vld) void'(q.pop_front());
      if (av && exp_rdy) q.push_back(ad);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_a_ready"}, a_ready, 1);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_b_data"}, b_data, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_aempty"}, almost_empty, 1);
  endtask

  initial begin
    // Power-on reset
    @(negedge clk); @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then a write offered during the read cycle is refused and retried
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    step(1, 8'h44, 0, 0);
    step(1, 8'h55, 1, 0);
    step(1, 8'h55, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // Simultaneous read and write at count 2
    step(1, 8'hA0, 0, 0);
    step(1, 8'hA1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'hB0 + 8'(i), 1, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);

    // Flush at count 3 with a write offered in the flush cycle
    step(1, 8'hC1, 0, 0);
    step(1, 8'hC2, 0, 0);
    step(1, 8'hC3, 0, 0);
    step(1, 8'hC4, 0, 1);
    step(0, 8'h00, 0, 0);
    step(1, 8'hD1, 1, 0);
    step(0, 8'h00, 1, 0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset between edges with three words held
    step(0, 8'h00, 1, 1);
    step(1, 8'hE1, 0, 0);
    step(1, 8'hE2, 0, 0);
    step(1, 8'hE3, 0, 0);
    a_valid = 1'b0; b_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'hF1, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
